uart_tx_tick: RTL and testbench
===============================

Name: uart_tx_tick

Overview:
- Serial UART transmitter clocked by a single-cycle enable pulse (baud_tick), not by a derived clock.
- baud_tick comes from the team's clock divider stage instantiated at the top level. That divider produces a one-`clk`-wide pulse at the configured bit rate.
- Accepts parallel bytes over a valid/ready handshake and emits framed serial data: start, data LSB-first, optional parity, stop.
- Sits between the command/telemetry source and the board TX pin.

Parameters:
- DATA_BITS, 8: data bits per frame; legal range 5..9; elaboration error outside.
- PARITY_EN, 0: 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
- STOP_BITS, 1: stop bits per frame; 1 or 2 only; elaboration error otherwise.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- baud_tick  input  1  one-cycle bit-rate enable pulse from the divider.
- tx_data  input  DATA_BITS  byte to send; sampled only on accept.
- tx_valid  input  1  source has data.
- tx_ready  output  1  block can accept; registered.
- tx  output  1  serial line; idle high; registered.
- tx_busy  output  1  high from accept until the frame completes.
- tx_done  output  1  one-cycle pulse at frame end.

Behaviour:
- Interface: one clock, `clk`; reset is asynchronous and active-low, `reset_n`.
- Reset values: tx=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, shift register=0, bit counter=0.
- Reset mid-frame:
  - tx returns to 1 immediately (asynchronously).
  - The frame is abandoned; no tx_done is produced.
- Accept: a rising edge with tx_valid=1 and tx_ready=1.
  - tx_data is latched into the shift register.
  - Parity is computed from the latched data.
  - Next cycle: tx_ready=0, tx_busy=1, state ARM.
  - After accept, tx_data and tx_valid are don't-care until tx_ready returns high.
- States: IDLE, ARM, START, DATA, PARITY, STOP.
  - IDLE: tx=1; tx_ready=1; waits for accept.
  - ARM: tx=1. A baud_tick in ARM moves to START, with tx=0 from the next cycle. A tick in the accept cycle itself is ignored. This aligns the start bit to a full tick period.
  - START: on tick, enter DATA; tx=data[0].
  - DATA: on each tick, shift right and increment the bit counter. After DATA_BITS ticks in DATA, go to PARITY if PARITY_EN=1, else STOP.
  - PARITY: tx=parity bit. Even parity is the XOR of all data bits; odd parity is its inverse. On tick, go to STOP.
  - STOP: tx=1 for STOP_BITS tick periods. On the final stop tick, go to IDLE and pulse tx_done=1 for one cycle. In that same cycle tx_ready=1 and tx_busy=0.
- Outside IDLE, state changes only on baud_tick; all other cycles hold.
- Frame length: 1 + DATA_BITS + PARITY_EN + STOP_BITS tick periods, plus the ARM wait for the first tick.
- Latency: tx falls exactly one `clk` cycle after the first baud_tick following accept.
- Back-to-back frames: tx_valid held high is accepted in the first cycle tx_ready=1. The stop bit(s) are always fully transmitted before the next start bit.
- tx_ready is never high while tx_busy is high.
- Tick rules:
  - baud_tick held high continuously means one bit per cycle; this is legal and is the minimum frame time.
  - A tick while in IDLE is ignored.
- Bit counter width: $clog2(DATA_BITS+1). Counter wrap is not possible by construction.

Decomposition:
- Shared package uart_pkg holds:
  - enum tx_state_t {IDLE, ARM, START, DATA, PARITY, STOP};
  - constants DATA_BITS_MIN=5 and DATA_BITS_MAX=9;
  - function frame_ticks(data_bits, parity_en, stop_bits), returning the frame length in ticks.
- Single module; no sub-module. The tick source remains a separate divider instance at the top level, not inside this block.

Test Plan:
- Default params, tick every 4 clk, send 0x55 → tx sequence per tick: 0,1,0,1,0,1,0,1,0,1. tx_done pulses once, 10 ticks after the start-bit edge.
- PARITY_EN=1, PARITY_ODD=0, send 0xA5 → parity bit 0. With PARITY_ODD=1 → parity bit 1. Frame is 11 ticks long.
- STOP_BITS=2, tx_valid held high with 0x0F then 0xF0 → two stop periods of tx=1 between frames. Second accept occurs in the tx_done cycle.
- baud_tick asserted in the same cycle as accept → tick ignored. Start bit begins on the next tick and lasts a full tick period.
- reset_n pulsed low during data bit 3 → tx=1 immediately; tx_ready=1 and tx_busy=0 after release; no tx_done. A new 0x3C frame then transmits correctly.
- baud_tick tied high, send 0x81 → one bit per clk: 0,1,0,0,0,0,0,0,1,1. tx_done on cycle 11 after accept.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types, limits and helpers for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;

    // Frame length in bit periods, excluding the wait for the first tick after accept.
    function automatic int frame_ticks(input int data_bits, input int parity_en, input int stop_bits);
        return 1 + data_bits + parity_en + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_tick.sv
// UART transmitter advanced by a one-cycle baud_tick enable; valid/ready byte input,
// framed LSB-first serial output with optional parity and one or two stop bits.
module uart_tx_tick
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int               CNT_W     = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    generate
        if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
            $error("uart_tx_tick: DATA_BITS must be in 5..9");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("uart_tx_tick: STOP_BITS must be 1 or 2");
        end
    endgenerate

    tx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // tx_d is the line level for the bit period that the current tick opens.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        parity_d = parity_q;
        tx_d     = tx_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (tx_valid && ready_q) begin
                    state_d  = ARM;
                    shift_d  = tx_data;
                    parity_d = (^tx_data) ^ (PARITY_ODD != 0);
                    cnt_d    = '0;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            ARM: begin
                if (baud_tick) begin
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shift_d = shift_q >> 1;
                    cnt_d   = cnt_q + CNT_ONE;
                    tx_d    = shift_d[0];
                    if (cnt_q == LAST_DATA) begin
                        cnt_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                    cnt_d   = '0;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (cnt_q == LAST_STOP) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_tick.sv
// Four transmitter configurations (8N1, 8E1, 8O1, 8N2) share clock, reset and tick;
// a bit-slot frame model is compared against every instance on each falling clock edge.
module tb_uart_tx_tick;
    import uart_pkg::*;

    localparam int            NI          = 4;
    localparam logic [NI-1:0] PAR_EN      = 4'b0110;
    localparam logic [NI-1:0] PAR_ODD     = 4'b0100;
    localparam logic [NI-1:0] STOP2       = 4'b1000;
    localparam int            TM_PERIODIC = 0;
    localparam int            TM_HIGH     = 1;
    localparam int            TM_MANUAL   = 2;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          baud_tick = 1'b0;
    logic [NI-1:0] tx_valid  = '0;
    logic [NI-1:0] tx_ready, tx, tx_busy, tx_done;
    logic [7:0]    tx_data [NI];

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]    src_mem [NI][8];
    int            src_cnt [NI];
    int            src_idx [NI];
    logic [NI-1:0] last_acc    = '0;
    int            tick_mode   = TM_PERIODIC;
    logic          tick_manual = 1'b0;
    int            cyc         = 0;

    logic [NI-1:0] m_busy    = '0;
    logic [NI-1:0] m_done    = '0;
    int            m_k [NI];
    logic [15:0]   m_bits [NI];
    logic          last_tick = 1'b0;

    logic [NI-1:0] prev_busy = '0;
    logic [31:0]   txlog [NI];
    int            txlog_n [NI];
    int            slots [NI];
    int            meas [NI];
    int            done_cnt [NI];
    int            acc_in_done [NI];
    logic          exp_tx_c;

    int base_n [NI];
    int base_done [NI];
    int base_aid [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        uart_tx_tick #(
            .DATA_BITS (8),
            .PARITY_EN (int'(PAR_EN[g])),
            .PARITY_ODD(int'(PAR_ODD[g])),
            .STOP_BITS (STOP2[g] ? 2 : 1)
        ) u_dut (
            .clk      (clk),
            .reset_n  (reset_n),
            .baud_tick(baud_tick),
            .tx_data  (tx_data[g]),
            .tx_valid (tx_valid[g]),
            .tx_ready (tx_ready[g]),
            .tx       (tx[g]),
            .tx_busy  (tx_busy[g]),
            .tx_done  (tx_done[g])
        );
    end

    function automatic int frame_len(input int i);
        return frame_ticks(8, int'(PAR_EN[i]), STOP2[i] ? 2 : 1);
    endfunction

    // Line level for each bit period of a frame: slot 0 is the start bit.
    function automatic logic [15:0] frame_slots(input int i, input logic [7:0] d);
        logic [15:0] s;
        s    = '1;
        s[0] = 1'b0;
        for (int b = 0; b < 8; b++) s[1+b] = d[b];
        if (PAR_EN[i]) s[9] = (^d) ^ PAR_ODD[i];
        return s;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: after accept, the k-th tick opens slot k-1; tick L+1 ends the frame.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy    <= '0;
            m_done    <= '0;
            last_tick <= 1'b0;
            for (int i = 0; i < NI; i++) m_k[i] <= 0;
        end else begin
            last_tick <= baud_tick;
            for (int i = 0; i < NI; i++) begin
                m_done[i] <= 1'b0;
                if (!m_busy[i]) begin
                    if (tx_valid[i]) begin
                        m_busy[i] <= 1'b1;
                        m_k[i]    <= 0;
                        m_bits[i] <= frame_slots(i, tx_data[i]);
                    end
                end else if (baud_tick) begin
                    m_k[i] <= m_k[i] + 1;
                    if (m_k[i] == frame_len(i)) begin
                        m_busy[i] <= 1'b0;
                        m_done[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            exp_tx_c = (m_busy[i] && m_k[i] >= 1) ? m_bits[i][m_k[i]-1] : 1'b1;
            check_output($sformatf("tx%0d", i), 32'(tx[i]), 32'(exp_tx_c));
            check_output($sformatf("tx_ready%0d", i), 32'(tx_ready[i]), 32'(!m_busy[i]));
            check_output($sformatf("tx_busy%0d", i), 32'(tx_busy[i]), 32'(m_busy[i]));
            check_output($sformatf("tx_done%0d", i), 32'(tx_done[i]), 32'(m_done[i]));
            if (!prev_busy[i] && tx_busy[i]) slots[i] = 0;
            if (last_tick && prev_busy[i] && tx_busy[i]) begin
                txlog[i] = {txlog[i][30:0], tx[i]};
                txlog_n[i]++;
                slots[i]++;
            end
            if (tx_done[i]) begin
                done_cnt[i]++;
                meas[i] = slots[i];
                if (tx_valid[i] && tx_ready[i]) acc_in_done[i]++;
            end
            prev_busy[i] = tx_busy[i];
        end
    end

    // One clock of stimulus: sample handshakes before the edge, update inputs just after it.
    task automatic apply_stimulus();
        @(negedge clk);
        last_acc = tx_valid & tx_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            if (last_acc[i] && reset_n) src_idx[i]++;
            tx_valid[i] = (src_idx[i] < src_cnt[i]);
            tx_data[i]  = src_mem[i][src_idx[i] % 8];
        end
        cyc++;
        case (tick_mode)
            TM_PERIODIC: baud_tick = (cyc % 4 == 0);
            TM_HIGH:     baud_tick = 1'b1;
            default:     baud_tick = tick_manual;
        endcase
    endtask

    task automatic push(input int i, input logic [7:0] d);
        src_mem[i][src_cnt[i]] = d;
        src_cnt[i]++;
    endtask

    task automatic snapshot();
        for (int i = 0; i < NI; i++) begin
            base_n[i]    = txlog_n[i];
            base_done[i] = done_cnt[i];
            base_aid[i]  = acc_in_done[i];
        end
    endtask

    task automatic wait_idle(input int budget, input string what);
        int  n;
        logic pending;
        n = 0;
        do begin
            apply_stimulus();
            n++;
            pending = (m_busy != '0);
            for (int i = 0; i < NI; i++) if (src_idx[i] < src_cnt[i]) pending = 1'b1;
        end while (pending && n < budget);
        check_output({what, " idle_within_budget"}, 32'(!pending), 32'd1);
        apply_stimulus();
        apply_stimulus();
    endtask

    initial begin
        int   n;
        int   cnt;
        int   d0;
        logic found;
        logic started;

        for (int i = 0; i < NI; i++) begin
            src_cnt[i] = 0; src_idx[i] = 0; tx_data[i] = '0; m_k[i] = 0; m_bits[i] = '1;
            txlog[i] = '0; txlog_n[i] = 0; slots[i] = 0; meas[i] = 0;
            done_cnt[i] = 0; acc_in_done[i] = 0;
        end

        #12;
        check_output("reset tx", 32'(tx), 32'hF);
        check_output("reset tx_ready", 32'(tx_ready), 32'hF);
        check_output("reset tx_busy", 32'(tx_busy), 32'h0);
        check_output("reset tx_done", 32'(tx_done), 32'h0);
        apply_stimulus();
        #2 reset_n = 1'b1;
        repeat (3) apply_stimulus();

        $display("[TB] frames: 8N1 0x55, 8E1/8O1 0xA5, 8N2 back-to-back 0x0F,0xF0");
        snapshot();
        push(0, 8'h55); push(1, 8'hA5); push(2, 8'hA5); push(3, 8'h0F); push(3, 8'hF0);
        wait_idle(400, "A");
        check_output("A log0", txlog[0][9:0], 32'b0101010101);
        check_output("A n0", txlog_n[0] - base_n[0], 10);
        check_output("A log1 even parity", txlog[1][10:0], 32'b01010010101);
        check_output("A log2 odd parity", txlog[2][10:0], 32'b01010010111);
        check_output("A n1", txlog_n[1] - base_n[1], 11);
        check_output("A log3 two frames", txlog[3][21:0], 32'b0111100001100000111111);
        check_output("A n3", txlog_n[3] - base_n[3], 22);
        check_output("A done0", done_cnt[0] - base_done[0], 1);
        check_output("A done3", done_cnt[3] - base_done[3], 2);
        check_output("A frame ticks 8N1", meas[0], 10);
        check_output("A frame ticks 8E1", meas[1], 11);
        check_output("A frame ticks 8O1", meas[2], 11);
        check_output("A frame ticks 8N2", meas[3], frame_len(3));
        check_output("A accept in done cycle", acc_in_done[3] - base_aid[3], 1);

        $display("[TB] tick in accept cycle, 0xC3");
        snapshot();
        tick_mode   = TM_MANUAL;
        tick_manual = 1'b1;
        push(0, 8'hC3);
        apply_stimulus();
        tick_manual = 1'b0;
        apply_stimulus();
        check_output("B accepted", 32'(last_acc[0]), 32'd1);
        check_output("B tx after ticked accept", 32'(tx[0]), 32'd1);
        check_output("B busy after accept", 32'(tx_busy[0]), 32'd1);
        repeat (3) apply_stimulus();
        check_output("B arm holds tx", 32'(tx[0]), 32'd1);
        tick_mode = TM_PERIODIC;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            apply_stimulus();
            if (tx[0] == 1'b0) found = 1'b1;
        end
        check_output("B start seen", 32'(found), 32'd1);
        cnt = 0;
        do begin apply_stimulus(); cnt++; end while (tx[0] == 1'b0 && cnt < 20);
        check_output("B start bit cycles", cnt, 4);
        wait_idle(200, "B");
        check_output("B log0", txlog[0][9:0], 32'b0110000111);
        check_output("B done0", done_cnt[0] - base_done[0], 1);

        $display("[TB] reset during data bit 3, then 0x3C");
        snapshot();
        push(0, 8'hF0);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            apply_stimulus();
            if (txlog_n[0] - base_n[0] >= 5) found = 1'b1;
        end
        check_output("C reached bit 3", 32'(found), 32'd1);
        check_output("C tx low before reset", 32'(tx[0]), 32'd0);
        d0 = done_cnt[0];
        #2 reset_n = 1'b0;
        #1 check_output("C async tx high", 32'(tx), 32'hF);
        apply_stimulus();
        apply_stimulus();
        #2 reset_n = 1'b1;
        apply_stimulus();
        check_output("C ready after reset", 32'(tx_ready[0]), 32'd1);
        check_output("C busy after reset", 32'(tx_busy[0]), 32'd0);
        repeat (48) apply_stimulus();
        check_output("C no done", done_cnt[0], d0);
        snapshot();
        push(0, 8'h3C);
        wait_idle(200, "C");
        check_output("C log0", txlog[0][9:0], 32'b0001111001);
        check_output("C done0", done_cnt[0] - base_done[0], 1);

        $display("[TB] baud_tick tied high, 0x81");
        snapshot();
        tick_mode = TM_HIGH;
        push(0, 8'h81);
        started = 1'b0;
        found   = 1'b0;
        n       = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            apply_stimulus();
            if (!started && last_acc[0]) begin
                started = 1'b1;
                n       = 0;
            end else if (started) begin
                n++;
                if (tx_done[0]) found = 1'b1;
            end
        end
        check_output("D done seen", 32'(found), 32'd1);
        check_output("D cycles accept to done", n, 11);
        wait_idle(50, "D");
        check_output("D log0", txlog[0][9:0], 32'b0100000011);
        check_output("D done0", done_cnt[0] - base_done[0], 1);
        tick_mode = TM_PERIODIC;
        repeat (4) apply_stimulus();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
